// File: rtl/dmem_access_unit.sv
// Multi-cycle load/store initiator for a word-addressed data memory.
// Handles byte/half/word accesses with lane select, extension and read-modify-write.
module dmem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_dout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_READ,
        S_STORE,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] wbuf_q, wbuf_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        req_misaligned;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [31:0] rmw_word;

    assign req_misaligned = (req_size == 2'b11)
                         || (req_size == 2'b01 && req_addr[0])
                         || (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    // Byte lanes of the merged store word: new data on the addressed lane(s), memory elsewhere.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic byte_hit;
            logic half_hit;
            assign byte_hit = (size_q == 2'b00) && (addr_q[1:0] == 2'(gi));
            assign half_hit = (size_q == 2'b01) && (addr_q[1] == 1'(gi / 2));
            assign rmw_word[8*gi +: 8] = byte_hit ? wdata_q[7:0] :
                                         half_hit ? wdata_q[8*(gi%2) +: 8] :
                                                    mem_dout[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        byte_sel = mem_dout[7:0];
        case (addr_q[1:0])
            2'd1:    byte_sel = mem_dout[15:8];
            2'd2:    byte_sel = mem_dout[23:16];
            2'd3:    byte_sel = mem_dout[31:24];
            default: byte_sel = mem_dout[7:0];
        endcase
        half_sel = addr_q[1] ? mem_dout[31:16] : mem_dout[15:0];
        case (size_q)
            2'b00:   load_val = uns_q ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_val = uns_q ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_val = mem_dout;
        endcase
    end

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wbuf_d  = wbuf_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    err_d   = req_misaligned;
                    if (req_misaligned) begin
                        state_d = S_RESP;
                    end else if (!req_write) begin
                        state_d = S_LOAD;
                    end else if (req_size == 2'b10) begin
                        wbuf_d  = req_wdata;
                        state_d = S_STORE;
                    end else begin
                        state_d = S_RMW_READ;
                    end
                end
            end
            S_LOAD: begin
                rdata_d = load_val;
                state_d = S_RESP;
            end
            S_RMW_READ: begin
                wbuf_d  = rmw_word;
                state_d = S_STORE;
            end
            S_STORE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Async clear drops mem_write immediately, so an interrupted store never lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wbuf_q  <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wbuf_q  <= wbuf_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign mem_read   = (state_q == S_LOAD) || (state_q == S_RMW_READ);
    assign mem_write  = (state_q == S_STORE);
    assign mem_addr   = (state_q == S_IDLE) ? 32'd0 : {addr_q[31:2], 2'b00};
    assign mem_din    = wbuf_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // write_q is kept with the latched request; routing uses the live request on accept.
    logic unused_write;
    assign unused_write = write_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed vector table, hand sequences
// and randomized requests against a byte-level reference model with a stub memory.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_din, mem_dout;
    logic        mem_read, mem_write;

    always #5 clk = ~clk;

    dmem_access_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_read(mem_read), .mem_write(mem_write), .mem_dout(mem_dout)
    );

    // Stub memory: 64 words, combinational read, write on rising edge.
    logic [31:0] tb_mem [0:63];
    logic [31:0] model_mem [0:63];
    logic        pl_we = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_data = 32'd0;

    assign mem_dout = tb_mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_write)
            tb_mem[mem_addr[7:2]] <= mem_din;
        else if (pl_we)
            tb_mem[pl_idx] <= pl_data;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit model_misaligned(input logic [1:0] sz, input logic [31:0] a);
        int nb;
        if (sz == 2'b11) return 1'b1;
        nb = 1 << sz;
        return (a % nb) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] sz,
                                               input logic u, input logic [31:0] a);
        int nb, off;
        logic [63:0] v, mask;
        nb   = 1 << sz;
        off  = int'(a[1:0]);
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v    = (64'(word) >> (8 * off)) & mask;
        if (!u && v[8*nb-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] word, input logic [1:0] sz,
                                                input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] r;
        int nb, off;
        r   = word;
        nb  = 1 << sz;
        off = int'(a[1:0]);
        for (int i = 0; i < nb; i++) r[8*(off+i) +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    // ---------------- one transaction ----------------
    task automatic run_req(input string tag, input logic w, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] wd, input int exp_lat,
                           input logic [31:0] exp_rdata, input logic exp_err,
                           input logic [31:0] exp_mem);
        int lat, rd_cnt, wr_cnt, rd_cyc, wr_cyc, bad_addr;
        int exp_rd, exp_wr;
        logic [31:0] got_rdata;
        logic        got_err;
        lat = 0; rd_cnt = 0; wr_cnt = 0; rd_cyc = 0; wr_cyc = 0; bad_addr = 0;
        got_rdata = 32'hx; got_err = 1'bx;
        check({tag, " ready"}, 32'(req_ready), 32'd1);
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        // Scramble the request bus: the unit must ignore it outside IDLE.
        req_valid    = 1'b0;
        req_addr     = $urandom;
        req_wdata    = $urandom;
        req_size     = 2'($urandom);
        req_write    = 1'($urandom);
        req_unsigned = 1'($urandom);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (mem_read) begin
                rd_cnt++; rd_cyc = n;
                if (mem_addr !== {a[31:2], 2'b00}) bad_addr++;
            end
            if (mem_write) begin
                wr_cnt++; wr_cyc = n;
                if (mem_addr !== {a[31:2], 2'b00}) bad_addr++;
            end
            if (resp_valid) begin
                lat = n; got_rdata = resp_rdata; got_err = resp_err;
                break;
            end
        end
        exp_rd = exp_err ? 0 : ((!w || sz != 2'b10) ? 1 : 0);
        exp_wr = exp_err ? 0 : (w ? 1 : 0);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " err"}, 32'(got_err), 32'(exp_err));
        check({tag, " rdata"}, got_rdata, exp_rdata);
        check({tag, " reads"}, 32'(rd_cnt), 32'(exp_rd));
        check({tag, " writes"}, 32'(wr_cnt), 32'(exp_wr));
        check({tag, " strobe_addr"}, 32'(bad_addr), 32'd0);
        if (!exp_err && w && sz != 2'b10)
            check({tag, " rmw_adjacent"}, 32'(wr_cyc), 32'(rd_cyc + 1));
        check({tag, " mem_word"}, tb_mem[a[7:2]], exp_mem);
        $display("txn %s w=%0d size=%0d u=%0d addr=%08h wdata=%08h -> rdata=%08h err=%0d lat=%0d mem=%08h",
                 tag, w, sz, u, a, wd, got_rdata, got_err, lat, tb_mem[a[7:2]]);
        @(negedge clk);
    endtask

    task automatic preload(input int idx, input logic [31:0] d);
        pl_idx = 6'(idx); pl_data = d; pl_we = 1'b1;
        @(posedge clk);
        #1;
        pl_we = 1'b0;
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] wd;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] mem;
    } vec_t;

    vec_t vecs [13];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepts, resps;
        logic [31:0] model_rdata;

        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 2, 32'h00000000, 1'b0, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        2, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h21, 32'h0,        2, 32'h0000007F, 1'b0, 32'h80FF7F01};
        vecs[3]  = '{1'b0, 2'd0, 1'b0, 32'h23, 32'h0,        2, 32'hFFFFFF80, 1'b0, 32'h80FF7F01};
        vecs[4]  = '{1'b0, 2'd0, 1'b1, 32'h22, 32'h0,        2, 32'h000000FF, 1'b0, 32'h80FF7F01};
        vecs[5]  = '{1'b0, 2'd1, 1'b0, 32'h22, 32'h0,        2, 32'hFFFF80FF, 1'b0, 32'h80FF7F01};
        vecs[6]  = '{1'b0, 2'd1, 1'b1, 32'h22, 32'h0,        2, 32'h000080FF, 1'b0, 32'h80FF7F01};
        vecs[7]  = '{1'b1, 2'd0, 1'b0, 32'h31, 32'h123456AA, 3, 32'h000080FF, 1'b0, 32'h1122AA44};
        vecs[8]  = '{1'b1, 2'd1, 1'b0, 32'h32, 32'h5555BEEF, 3, 32'h000080FF, 1'b0, 32'hBEEFAA44};
        vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h30, 32'h0,        2, 32'hBEEFAA44, 1'b0, 32'hBEEFAA44};
        vecs[10] = '{1'b0, 2'd2, 1'b0, 32'h41, 32'h0,        1, 32'hBEEFAA44, 1'b1, 32'hCAFEF00D};
        vecs[11] = '{1'b1, 2'd1, 1'b0, 32'h43, 32'h0000FFFF, 1, 32'hBEEFAA44, 1'b1, 32'hCAFEF00D};
        vecs[12] = '{1'b0, 2'd3, 1'b0, 32'h40, 32'h0,        1, 32'hBEEFAA44, 1'b1, 32'hCAFEF00D};

        reset = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;

        // Memory preload happens while the unit is held in reset.
        for (int i = 0; i < 64; i++) preload(i, 32'h01010101 * i ^ 32'hA5A50000);
        preload(4,  32'h00000000);
        preload(8,  32'h80FF7F01);
        preload(12, 32'h11223344);
        preload(16, 32'hCAFEF00D);
        preload(20, 32'h0BADF00D);

        @(negedge clk);
        check("rst req_ready", 32'(req_ready), 32'd1);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst mem_read", 32'(mem_read), 32'd0);
        check("rst mem_write", 32'(mem_write), 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst mem_din", mem_din, 32'd0);
        check("rst resp_rdata", resp_rdata, 32'd0);
        check("rst resp_err", 32'(resp_err), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++)
            run_req($sformatf("vec%0d", i), vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a,
                    vecs[i].wd, vecs[i].lat, vecs[i].rdata, vecs[i].err, vecs[i].mem);

        // req_valid held high: word loads from 0x10, one accept every 3 cycles.
        accepts = 0; resps = 0;
        req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10;
        req_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (req_ready) accepts++;
            if (resp_valid) begin
                resps++;
                check("hs rdata", resp_rdata, 32'hDEADBEEF);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (resp_valid) resps++;
            @(negedge clk);
        end
        check("hs accepts", 32'(accepts), 32'd3);
        check("hs responses", 32'(resps), 32'd3);
        $display("txn handshake accepts=%0d responses=%0d", accepts, resps);

        // Reset asserted while the store strobe is high.
        req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h50; req_wdata = 32'h12345678; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rs store_strobe", 32'(mem_write), 32'd1);
        reset = 1'b0;
        #1;
        check("rs mem_write", 32'(mem_write), 32'd0);
        check("rs req_ready", 32'(req_ready), 32'd1);
        check("rs resp_valid", 32'(resp_valid), 32'd0);
        check("rs mem_addr", mem_addr, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rs post_valid", 32'(resp_valid), 32'd0);
            check("rs post_ready", 32'(req_ready), 32'd1);
        end
        check("rs mem_word", tb_mem[20], 32'h0BADF00D);
        check("rs rdata", resp_rdata, 32'd0);
        $display("txn reset_in_store mem[0x50]=%08h", tb_mem[20]);

        // Randomized requests against the reference model.
        for (int i = 0; i < 64; i++) model_mem[i] = tb_mem[i];
        model_rdata = 32'd0;
        for (int t = 0; t < 150; t++) begin
            logic        w, u, err;
            logic [1:0]  sz;
            logic [31:0] a, wd;
            int          lat, idx;
            w   = 1'($urandom);
            u   = 1'($urandom);
            sz  = 2'($urandom);
            a   = 32'($urandom_range(0, 255));
            wd  = $urandom;
            idx = int'(a[7:2]);
            err = model_misaligned(sz, a);
            if (err) begin
                lat = 1;
            end else if (!w) begin
                lat = 2;
                model_rdata = model_load(model_mem[idx], sz, u, a);
            end else begin
                lat = (sz == 2'b10) ? 2 : 3;
                model_mem[idx] = model_store(model_mem[idx], sz, a, wd);
            end
            run_req($sformatf("rnd%0d", t), w, sz, u, a, wd, lat, model_rdata, err,
                    model_mem[idx]);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
